// File: rtl/main_control_fsm.sv
// main_control_fsm
// Multicycle main control unit for the RV32 core. Sequences each instruction
// through fetch, decode, execute, memory and write-back states. Supports lw,
// sw, R-type and beq. Drives the datapath mux selects and enable strobes, and
// counts retired instructions.
//
// Handshake: mem_ready is a one-sided completion strobe. It is only looked at
// in FETCH, MEM_READ and MEM_WRITE. In those states a cycle with mem_ready=1
// completes the access and the FSM advances on that edge. A cycle with
// mem_ready=0 holds the state, and all strobes stay unchanged.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run               sequencing enable, sampled in IDLE and at boundaries
//   opcode[6:0]       instruction register opcode, valid from DECODE on
//   mem_ready         memory completes the current access this cycle
//   ALUOp[1:0]        00 add, 01 subtract, 10 funct-decoded
//   ALUSrcA           0 = PC, 1 = register A
//   ALUSrcB[1:0]      00 = register B, 01 = constant 4, 10 = immediate
//   IorD              memory address: 0 = PC, 1 = ALUOut
//   MemRead, MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond  strobes
//   MemtoReg          write-back source: 1 = MDR, 0 = ALUOut
//   PCSource          0 = ALU result, 1 = ALUOut
//   illegal_instr     unsupported opcode seen in DECODE
//   state[3:0]        current state encoding (debug)
//   instr_count       retired-instruction counter, wraps
module main_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             MemtoReg,
    output logic             PCSource,
    output logic             illegal_instr,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    state_t           boundary;

    // Where an instruction goes once it is finished (or rejected).
    assign boundary = run ? S_FETCH : S_IDLE;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter. Illegal opcodes leave DECODE directly
    // and so never pass through a retiring state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Next state, retire flag and control decode
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        ALUOp         = 2'b00;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        MemtoReg      = 1'b0;
        PCSource      = 1'b0;
        illegal_instr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR and PC+4 are captured only on the cycle the read lands.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // PC + imm goes into ALUOut as a speculative branch target.
                ALUSrcB = 2'b10;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = boundary;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    // Opcode changed under us; abandon without retiring.
                    state_d = boundary;
                end
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = boundary;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = boundary;
                end
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = boundary;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                retire      = 1'b1;
                state_d     = boundary;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_main_control_fsm.sv
module tb_main_control_fsm;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        run;
  logic [6:0]  opcode;
  logic        mem_ready;

  logic [1:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        iord, mem_read, mem_write, ir_write, reg_write;
  logic        pc_write, pc_write_cond, memto_reg, pc_source, illegal;
  logic [3:0]  state;
  logic [31:0] instr_count;

  // Narrow-counter instance, same stimulus, used to exercise counter wrap.
  logic [1:0]  n_alu_op;
  logic        n_alu_src_a;
  logic [1:0]  n_alu_src_b;
  logic        n_iord, n_mem_read, n_mem_write, n_ir_write, n_reg_write;
  logic        n_pc_write, n_pc_write_cond, n_memto_reg, n_pc_source, n_illegal;
  logic [3:0]  n_state;
  logic [1:0]  n_instr_count;

  main_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .ALUOp(alu_op), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .IorD(iord),
    .MemRead(mem_read), .MemWrite(mem_write), .IRWrite(ir_write),
    .RegWrite(reg_write), .PCWrite(pc_write), .PCWriteCond(pc_write_cond),
    .MemtoReg(memto_reg), .PCSource(pc_source), .illegal_instr(illegal),
    .state(state), .instr_count(instr_count)
  );

  main_control_fsm #(.CNT_W(2)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .ALUOp(n_alu_op), .ALUSrcA(n_alu_src_a), .ALUSrcB(n_alu_src_b), .IorD(n_iord),
    .MemRead(n_mem_read), .MemWrite(n_mem_write), .IRWrite(n_ir_write),
    .RegWrite(n_reg_write), .PCWrite(n_pc_write), .PCWriteCond(n_pc_write_cond),
    .MemtoReg(n_memto_reg), .PCSource(n_pc_source), .illegal_instr(n_illegal),
    .state(n_state), .instr_count(n_instr_count)
  );

  // Control word: {ALUOp, SrcA, SrcB, IorD, MemRead, MemWrite, IRWrite,
  //                RegWrite, PCWrite, PCWriteCond, MemtoReg, PCSource, illegal}
  logic [14:0] ctrl;
  logic [14:0] n_ctrl;
  assign ctrl = {alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
                 reg_write, pc_write, pc_write_cond, memto_reg, pc_source, illegal};
  assign n_ctrl = {n_alu_op, n_alu_src_a, n_alu_src_b, n_iord, n_mem_read, n_mem_write,
                   n_ir_write, n_reg_write, n_pc_write, n_pc_write_cond, n_memto_reg,
                   n_pc_source, n_illegal};

  //                               AO SA SB I R W IR RW PW PC MR PS IL
  localparam logic [14:0] C_IDLE   = 15'b00_0_01_0_0_0_0_0_0_0_0_0_0 & 15'b0;
  localparam logic [14:0] C_F_RDY  = 15'b00_0_01_0_1_0_1_0_1_0_0_0_0;
  localparam logic [14:0] C_F_STL  = 15'b00_0_01_0_1_0_0_0_0_0_0_0_0;
  localparam logic [14:0] C_DEC    = 15'b00_0_10_0_0_0_0_0_0_0_0_0_0;
  localparam logic [14:0] C_DEC_IL = 15'b00_0_10_0_0_0_0_0_0_0_0_0_1;
  localparam logic [14:0] C_MADDR  = 15'b00_1_10_0_0_0_0_0_0_0_0_0_0;
  localparam logic [14:0] C_MREAD  = 15'b00_0_00_1_1_0_0_0_0_0_0_0_0;
  localparam logic [14:0] C_MWRITE = 15'b00_0_00_1_0_1_0_0_0_0_0_0_0;
  localparam logic [14:0] C_MWB    = 15'b00_0_00_0_0_0_0_1_0_0_1_0_0;
  localparam logic [14:0] C_EXEC   = 15'b10_1_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [14:0] C_ALUWB  = 15'b00_0_00_0_0_0_0_1_0_0_0_0_0;
  localparam logic [14:0] C_BRANCH = 15'b01_1_00_0_0_0_0_0_0_1_0_1_0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic        run;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [14:0] exp_ctrl;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic add_vec(input logic r, input logic [6:0] op, input logic mr,
                         input logic [3:0] st, input logic [14:0] c, input logic [31:0] n);
    vec_t v;
    v.run = r; v.opcode = op; v.mem_ready = mr;
    v.exp_state = st; v.exp_ctrl = c; v.exp_cnt = n;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [6:0] op, input logic mr);
    @(negedge clk);
    run = r; opcode = op; mem_ready = mr;
  endtask

  initial begin
    // Each vector: inputs for one cycle, and the state/outputs/count
    // expected during that cycle (before the next rising edge).
    add_vec(0, RT,  1, 0, C_IDLE,   0); // idle, run low: stay
    add_vec(1, RT,  1, 0, C_IDLE,   0); // run high -> FETCH
    // R-type: 1,2,7,8
    add_vec(1, RT,  1, 1, C_F_RDY,  0);
    add_vec(1, RT,  1, 2, C_DEC,    0);
    add_vec(1, RT,  1, 7, C_EXEC,   0);
    add_vec(1, RT,  1, 8, C_ALUWB,  0);
    // lw with 3 stall cycles in MEM_READ
    add_vec(1, LW,  1, 1, C_F_RDY,  1);
    add_vec(1, LW,  1, 2, C_DEC,    1);
    add_vec(1, LW,  1, 3, C_MADDR,  1);
    add_vec(1, LW,  0, 4, C_MREAD,  1);
    add_vec(1, LW,  0, 4, C_MREAD,  1);
    add_vec(1, LW,  0, 4, C_MREAD,  1);
    add_vec(1, LW,  1, 4, C_MREAD,  1);
    add_vec(1, LW,  1, 5, C_MWB,    1);
    // sw then beq back-to-back
    add_vec(1, SW,  1, 1, C_F_RDY,  2);
    add_vec(1, SW,  1, 2, C_DEC,    2);
    add_vec(1, SW,  1, 3, C_MADDR,  2);
    add_vec(1, SW,  1, 6, C_MWRITE, 2);
    add_vec(1, BEQ, 1, 1, C_F_RDY,  3);
    add_vec(1, BEQ, 1, 2, C_DEC,    3);
    add_vec(1, BEQ, 1, 9, C_BRANCH, 3);
    // fetch stall, then illegal opcode
    add_vec(1, BAD, 0, 1, C_F_STL,  4);
    add_vec(1, BAD, 1, 1, C_F_RDY,  4);
    add_vec(1, BAD, 1, 2, C_DEC_IL, 4);
    // R-type with run dropped during EXECUTE
    add_vec(1, RT,  1, 1, C_F_RDY,  4);
    add_vec(1, RT,  1, 2, C_DEC,    4);
    add_vec(0, RT,  1, 7, C_EXEC,   4);
    add_vec(0, RT,  1, 8, C_ALUWB,  4);
    add_vec(0, RT,  1, 0, C_IDLE,   5);
    // sw: mem_ready ignored in DECODE/MEM_ADDR, stalled in MEM_WRITE
    add_vec(1, SW,  1, 0, C_IDLE,   5);
    add_vec(1, SW,  1, 1, C_F_RDY,  5);
    add_vec(1, SW,  0, 2, C_DEC,    5);
    add_vec(1, SW,  0, 3, C_MADDR,  5);
    add_vec(1, SW,  0, 6, C_MWRITE, 5);
    add_vec(0, SW,  1, 6, C_MWRITE, 5);
    add_vec(0, SW,  1, 0, C_IDLE,   6);

    // ---- reset ----
    run = 1'b0; opcode = 7'd0; mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_ctrl",  {17'd0, ctrl}, 32'd0);
    check("reset_count", instr_count, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].run, vecs[i].opcode, vecs[i].mem_ready);
      #1;
      exp_q.push_back(vecs[i].exp_cnt);
      check($sformatf("v%0d_state", i), {28'd0, state}, {28'd0, vecs[i].exp_state});
      check($sformatf("v%0d_ctrl", i),  {17'd0, ctrl}, {17'd0, vecs[i].exp_ctrl});
      check($sformatf("v%0d_count", i), instr_count, exp_q.pop_front());
      check($sformatf("v%0d_nstate", i), {28'd0, n_state}, {28'd0, vecs[i].exp_state});
      check($sformatf("v%0d_ncount", i), {30'd0, n_instr_count}, {30'd0, vecs[i].exp_cnt[1:0]});
    end

    // After 6 retirements the 2-bit counter has wrapped once: 6 mod 4.
    check("narrow_wrap", {30'd0, n_instr_count}, 32'd2);
    check("narrow_ctrl_match", {17'd0, n_ctrl}, 32'd0);

    // ---- asynchronous reset mid-stall in MEM_READ ----
    drive(1, LW, 1);      // IDLE -> FETCH
    drive(1, LW, 1);      // FETCH -> DECODE
    drive(1, LW, 1);      // DECODE -> MEM_ADDR
    drive(1, LW, 0);      // MEM_ADDR -> MEM_READ
    drive(1, LW, 0);      // stall
    #1;
    check("stall_state", {28'd0, state}, 32'd4);
    check("stall_ctrl",  {17'd0, ctrl}, {17'd0, C_MREAD});
    check("stall_count", instr_count, 32'd6);
    #1;
    rst_n = 1'b0;          // between edges
    #1;
    check("async_rst_state", {28'd0, state}, 32'd0);
    check("async_rst_ctrl",  {17'd0, ctrl}, 32'd0);
    check("async_rst_count", instr_count, 32'd0);
    check("async_rst_ncount", {30'd0, n_instr_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_idle", {28'd0, state}, 32'd0);

    // ---- first FETCH on first edge with run=1 after release ----
    drive(1, RT, 1);
    #1;
    check("pre_fetch_idle", {28'd0, state}, 32'd0);
    drive(1, RT, 1);
    #1;
    check("first_fetch", {28'd0, state}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main control unit for the RV32 core. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath mux and enable strobes. It produces the 2-bit `ALUOp` consumed by the ALU control decoder. It supports lw, sw, R-type and beq, stalls on a memory ready handshake, and keeps a retired-instruction counter.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  enables sequencing; sampled in IDLE and at instruction boundaries.
- `opcode`  in  7  instruction register bits [6:0]; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `ALUOp`  out  2  00 add, 01 subtract (beq), 10 funct-decoded (R-type).
- `ALUSrcA`  out  1  0 = PC, 1 = register A.
- `ALUSrcB`  out  2  00 = register B, 01 = constant 4, 10 = immediate.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`, `PCWrite`, `PCWriteCond`  out  1 each  datapath strobes.
- `MemtoReg`  out  1  write-back source: 1 = memory data register, 0 = ALUOut.
- `PCSource`  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- `illegal_instr`  out  1  unsupported opcode seen in DECODE.
- `state`  out  4  current state encoding, for debug.
- `instr_count`  out  CNT_W  number of retired instructions.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9. Codes 10–15 are unreachable; if entered, the next state is IDLE.
- All control outputs are a pure decode of `state`, plus `mem_ready`/`opcode` where noted. Any output not listed for a state is 0.
- IDLE: all strobes 0.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=0. `IRWrite` = `PCWrite` = `mem_ready`.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=10, `ALUOp`=00 (branch target goes into ALUOut). `illegal_instr`=1 when the opcode is not supported.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
- MEM_READ: `MemRead`=1, `IorD`=1.
- MEM_WRITE: `MemWrite`=1, `IorD`=1.
- MEM_WB: `RegWrite`=1, `MemtoReg`=1.
- EXECUTE: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10.
- ALU_WB: `RegWrite`=1, `MemtoReg`=0.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=1.
- Transitions:
  - IDLE → FETCH when `run`=1.
  - FETCH → DECODE when `mem_ready`=1; otherwise stay in FETCH.
  - DECODE by opcode: 0000011 or 0100011 → MEM_ADDR; 0110011 → EXECUTE; 1100011 → BRANCH; any other opcode → boundary.
  - MEM_ADDR → MEM_READ for lw, → MEM_WRITE for sw (opcode re-checked here).
  - MEM_READ → MEM_WB on `mem_ready`; otherwise hold.
  - MEM_WRITE → boundary on `mem_ready`; otherwise hold.
  - EXECUTE → ALU_WB.
  - MEM_WB, ALU_WB, BRANCH → boundary.
- Boundary: the next state is FETCH if `run`=1, else IDLE. Dropping `run` mid-instruction never aborts the instruction.
- Retire: `instr_count` increments by 1 on the edge that leaves MEM_WB, ALU_WB or BRANCH, or leaves MEM_WRITE with `mem_ready`=1.
  - Illegal opcodes do not retire.
  - The counter wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (asynchronous, at any time, including mid-stall): `state`=IDLE, `instr_count`=0, so every control output is 0 immediately.
- After `rst_n` is released, the first FETCH occurs on the first edge with `run`=1.
- Latency with `mem_ready` held at 1:
  - R-type: 4 cycles (1,2,7,8).
  - lw: 5 cycles (1,2,3,4,5).
  - sw: 4 cycles (1,2,3,6).
  - beq: 3 cycles (1,2,9).
  - Illegal opcode: 2 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Strobes stay constant while stalled.
- `mem_ready` is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.

## Test plan
- Reset mid-stall: with `mem_ready`=0 in MEM_READ, pulse `rst_n` low between edges → `state`=0 and all outputs 0 asynchronously; `instr_count`=0.
- R-type, `run`=1, `mem_ready`=1, opcode 0110011 → state sequence 1,2,7,8,1; `ALUOp`=10 in state 7; `RegWrite`=1 only in state 8; `instr_count` 0→1.
- lw with `mem_ready`=0 for 3 cycles in MEM_READ → states 1,2,3,4,4,4,4,5; `MemRead`=`IorD`=1 throughout state 4; `MemtoReg`=`RegWrite`=1 in state 5.
- sw then beq back-to-back → sw shows `MemWrite`=1 in state 6 only; beq shows `ALUOp`=01, `PCWriteCond`=1, `PCSource`=1 in state 9; `instr_count`=2.
- Opcode 1111111 → `illegal_instr`=1 for exactly one cycle in state 2; next state is 1; `instr_count` unchanged.
- Drop `run` during EXECUTE → ALU_WB still completes, then `state`=0. Separately, preload `instr_count` to 0xFFFFFFFF and retire one instruction → `instr_count`=0.
